// File: rtl/array_scheduler_if.sv
// Control/status bundle between the array scheduler and its host/array edge.
interface array_scheduler_if #(
  parameter int K_WIDTH    = 8,
  parameter int ADDR_WIDTH = 10
);
  logic                  start;
  logic [K_WIDTH-1:0]    k_len;
  logic [7:0]            num_tiles;
  logic                  array_full;
  logic                  psum_vld;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  rst_acc;
  logic                  stream_out_rdy;
  logic                  stall;
  logic                  busy;
  logic                  done;
  logic                  err;

  modport master (
    output start, k_len, num_tiles, array_full, psum_vld,
    input  rd_en, rd_addr, rst_acc, stream_out_rdy, stall, busy, done, err
  );

  modport slave (
    input  start, k_len, num_tiles, array_full, psum_vld,
    output rd_en, rd_addr, rst_acc, stream_out_rdy, stall, busy, done, err
  );
endinterface

// File: rtl/array_scheduler.sv
// Tile sequencer for a ROWS x COLS systolic array: streams k_len operand
// beats per tile, waits for the MAC pipeline to flush, captures partial
// sums, and reports job completion once every result beat has left the array.
module array_scheduler #(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int K_WIDTH    = 8,
  parameter int ADDR_WIDTH = 10,
  parameter int PIPE_LAT   = 4
) (
  input logic             clk,
  input logic             rst,
  array_scheduler_if.slave bus
);

  typedef enum logic [2:0] {IDLE, COMPUTE, FLUSH, CAPTURE, DRAIN} state_t;

  localparam int          FLUSH_LEN    = PIPE_LAT + ROWS + COLS - 2;
  localparam int          FLUSH_W      = $clog2(FLUSH_LEN + 1);
  localparam logic [15:0] TILE_RESULTS = 16'(ROWS * COLS);

  state_t                state, state_next;
  logic [K_WIDTH-1:0]    k_len_q, beat_cnt;
  logic [7:0]            tiles_q, tile_cnt;
  logic [FLUSH_W-1:0]    flush_cnt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [15:0]           res_cnt, res_target;

  logic hold, launch, bad_start, last_beat, last_flush, last_tile, drain_done;
  logic rd_en, rst_acc, stream_out_rdy, done, err;

  assign hold       = bus.array_full;
  assign launch     = (state == IDLE) && bus.start && (bus.k_len != '0) && (bus.num_tiles != '0);
  assign bad_start  = (state == IDLE) && bus.start && ((bus.k_len == '0) || (bus.num_tiles == '0));
  assign last_beat  = (beat_cnt == k_len_q - K_WIDTH'(1));
  assign last_flush = (flush_cnt == FLUSH_W'(FLUSH_LEN - 1));
  assign last_tile  = ((tile_cnt + 8'd1) == tiles_q);
  assign res_target = 16'(tiles_q) * TILE_RESULTS;
  assign drain_done = (res_cnt >= res_target);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state decode and per-cycle strobes; a stall freezes the FSM and kills strobes
  always_comb begin
    state_next     = state;
    rd_en          = 1'b0;
    rst_acc        = 1'b0;
    stream_out_rdy = 1'b0;
    done           = 1'b0;
    err            = 1'b0;
    case (state)
      IDLE: begin
        err = bad_start;
        if (launch) state_next = COMPUTE;
      end
      COMPUTE: if (!hold) begin
        rd_en   = 1'b1;
        rst_acc = (beat_cnt == '0);
        if (last_beat) state_next = FLUSH;
      end
      FLUSH: if (!hold && last_flush) state_next = CAPTURE;
      CAPTURE: if (!hold) begin
        stream_out_rdy = 1'b1;
        state_next     = last_tile ? DRAIN : COMPUTE;
      end
      DRAIN: if (!hold && drain_done) begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (rst) begin
      state_next     = IDLE;
      rd_en          = 1'b0;
      rst_acc        = 1'b0;
      stream_out_rdy = 1'b0;
      done           = 1'b0;
      err            = 1'b0;
    end
  end

  // Job parameters, beat/flush/tile/address counters and result counter
  always_ff @(posedge clk) begin
    if (rst) begin
      k_len_q   <= '0;
      tiles_q   <= '0;
      beat_cnt  <= '0;
      flush_cnt <= '0;
      tile_cnt  <= '0;
      addr_q    <= '0;
      res_cnt   <= '0;
    end else if (launch) begin
      k_len_q   <= bus.k_len;
      tiles_q   <= bus.num_tiles;
      beat_cnt  <= '0;
      flush_cnt <= '0;
      tile_cnt  <= '0;
      addr_q    <= '0;
      res_cnt   <= '0;
    end else if (state != IDLE) begin
      // results keep arriving from the array edge even while it is stalled
      if (bus.psum_vld) res_cnt <= res_cnt + 16'd1;
      if (!hold) begin
        case (state)
          COMPUTE: begin
            addr_q   <= addr_q + ADDR_WIDTH'(1);
            beat_cnt <= last_beat ? '0 : beat_cnt + K_WIDTH'(1);
          end
          FLUSH:   flush_cnt <= last_flush ? '0 : flush_cnt + FLUSH_W'(1);
          CAPTURE: tile_cnt  <= tile_cnt + 8'd1;
          default: ;
        endcase
      end
    end
  end

  assign bus.rd_en          = rd_en;
  assign bus.rd_addr        = rst ? '0 : addr_q;
  assign bus.rst_acc        = rst_acc;
  assign bus.stream_out_rdy = stream_out_rdy;
  assign bus.stall          = bus.array_full & ~rst;
  assign bus.busy           = (state != IDLE) & ~rst;
  assign bus.done           = done;
  assign bus.err            = err;

endmodule
